// File: rtl/clock_pkg.sv
// Shared encodings for the CPU clock controller.
// Build option CLOCK_CPU_DEBOUNCE_EN enables the step-input stability filter.
package clock_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StStepIdle = 2'd1,
    StStepHigh = 2'd2,
    StHalted   = 2'd3
  } state_e;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

`ifdef CLOCK_CPU_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

endpackage

// File: rtl/clock_debounce.sv
// Two-flop synchroniser for the step button, plus an optional stability filter
// (present only when CLOCK_CPU_DEBOUNCE_EN is defined).
module clock_debounce
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  // Zero stable cycles means the filter is bypassed entirely.
  localparam int unsigned StableCycles = DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0;

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], in};
    end
  end

  if (StableCycles != 0) begin : g_filter
    localparam int unsigned CntW = (StableCycles > 1) ? $clog2(StableCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

    logic [CntW-1:0] cnt_q;
    logic            out_q;

    // Accept a new level only after it differs from the output for StableCycles clks.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        out_q <= 1'b0;
      end else if (sync_q[1] == out_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        cnt_q <= '0;
        out_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign out = out_q;
  end else begin : g_bypass
    assign out = sync_q[1];
  end

endmodule

// File: rtl/clock_cpu_ctrl.sv
// CPU clock generator: programmable free-run divider, single-step and halt.
// CLOCK_CPU_DEBOUNCE_EN (see clock_pkg) adds a stability filter on step.
module clock_cpu_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned DEFAULT_HALF    = 5000000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] half_period,
  input  logic                 load,
  input  logic                 mode,
  input  logic                 step,
  input  logic                 halt,
  output logic                 clk_cpu,
  output logic                 clk_cpu_rise,
  output logic                 clk_cpu_fall
);

  localparam logic [CNT_WIDTH-1:0] One = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] norm_half(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? One : v;
  endfunction

  state_e               state_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] half_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 clk_cpu_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 step_db;
  logic                 step_db_q;
  logic                 step_rise;
  logic                 phase_end;

  clock_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .in   (step),
    .out  (step_db)
  );

  assign step_rise = step_db & ~step_db_q;
  // half_q is the length of the phase in progress; period_q only lands at a boundary.
  assign phase_end = (cnt_q == half_q - One);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (mode == MODE_STEP) ? StStepIdle : StRun;
      period_q  <= CNT_WIDTH'(DEFAULT_HALF);
      half_q    <= norm_half(CNT_WIDTH'(DEFAULT_HALF));
      cnt_q     <= '0;
      clk_cpu_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      step_db_q <= 1'b0;
    end else begin
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      step_db_q <= step_db;
      if (load) begin
        period_q <= half_period;
      end
      unique case (state_q)
        StRun, StStepHigh: begin
          if (!clk_cpu_q && halt) begin
            state_q <= StHalted;
            cnt_q   <= '0;
          end else if (!clk_cpu_q && (mode == MODE_STEP)) begin
            state_q <= StStepIdle;
            cnt_q   <= '0;
          end else if (phase_end) begin
            cnt_q     <= '0;
            half_q    <= norm_half(period_q);
            clk_cpu_q <= ~clk_cpu_q;
            rise_q    <= ~clk_cpu_q;
            fall_q    <= clk_cpu_q;
            if (clk_cpu_q) begin
              if (halt) begin
                state_q <= StHalted;
              end else if (mode == MODE_STEP) begin
                state_q <= StStepIdle;
              end else begin
                state_q <= StRun;
              end
            end
          end else begin
            cnt_q <= cnt_q + One;
          end
        end
        StStepIdle: begin
          cnt_q  <= '0;
          half_q <= norm_half(period_q);
          if (halt) begin
            state_q <= StHalted;
          end else if (mode == MODE_RUN) begin
            state_q <= StRun;
          end else if (step_rise) begin
            clk_cpu_q <= 1'b1;
            rise_q    <= 1'b1;
            state_q   <= StStepHigh;
          end
        end
        StHalted: begin
          cnt_q     <= '0;
          half_q    <= norm_half(period_q);
          clk_cpu_q <= 1'b0;
          if (!halt) begin
            state_q <= (mode == MODE_STEP) ? StStepIdle : StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign clk_cpu      = clk_cpu_q;
  assign clk_cpu_rise = rise_q;
  assign clk_cpu_fall = fall_q;

endmodule

// File: tb/tb_clock_cpu_ctrl.sv
// Directed bench for clock_cpu_ctrl: per-cycle vector table plus hand-written
// reset and debounce sequences.
module tb_clock_cpu_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] half_period;
  logic       load;
  logic       mode;
  logic       step;
  logic       halt;
  logic       clk_cpu;
  logic       clk_cpu_rise;
  logic       clk_cpu_fall;

  clock_cpu_ctrl #(
    .CNT_WIDTH      (8),
    .DEFAULT_HALF   (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .half_period (half_period),
    .load        (load),
    .mode        (mode),
    .step        (step),
    .halt        (halt),
    .clk_cpu     (clk_cpu),
    .clk_cpu_rise(clk_cpu_rise),
    .clk_cpu_fall(clk_cpu_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [7:0] half;
    logic       mode;
    logic       halt;
    logic       step;
    logic [2:0] exp;   // {clk_cpu, rise, fall}
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  logic       c_mode, c_halt, c_step, p_load;
  logic [7:0] p_half;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic row(input logic c, input logic r, input logic f);
    vec_t v;
    v.load = p_load;
    v.half = p_half;
    v.mode = c_mode;
    v.halt = c_halt;
    v.step = c_step;
    v.exp  = {c, r, f};
    vecs.push_back(v);
    p_load = 1'b0;
  endtask

  task automatic phase(input int len, input logic lvl);
    for (int i = 0; i < len; i++) row(lvl, lvl && (i == 0), !lvl && (i == 0));
  endtask

  initial begin
    int   rise_at;
    int   rises;
    logic found;
    logic saw_high;

    c_mode = 1'b0; c_halt = 1'b0; c_step = 1'b0; p_load = 1'b0; p_half = 8'd0;

    // Free-run from reset, eff 4
    repeat (3) row(1'b0, 1'b0, 1'b0);
    phase(4, 1'b1); phase(4, 1'b0); phase(4, 1'b1); phase(4, 1'b0);
    // Load 2 during a high phase: it still lasts 4
    row(1'b1, 1'b1, 1'b0);
    p_load = 1'b1; p_half = 8'd2;
    repeat (3) row(1'b1, 1'b0, 1'b0);
    phase(2, 1'b0); phase(2, 1'b1); phase(2, 1'b0); phase(2, 1'b1);
    // Load 0: acts as 1, strobes alternate
    p_load = 1'b1; p_half = 8'd0;
    phase(2, 1'b0);
    phase(1, 1'b1); phase(1, 1'b0); phase(1, 1'b1); phase(1, 1'b0);
    // Back to 4, then halt one cycle after a rise
    p_load = 1'b1; p_half = 8'd4;
    phase(1, 1'b1);
    phase(4, 1'b0);
    row(1'b1, 1'b1, 1'b0);
    c_halt = 1'b1;
    repeat (3) row(1'b1, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b1);
    repeat (4) row(1'b0, 1'b0, 1'b0);
    c_halt = 1'b0;
    repeat (4) row(1'b0, 1'b0, 1'b0);
    phase(4, 1'b1);
    // Halt during a low phase restarts a full low phase
    row(1'b0, 1'b0, 1'b1);
    c_halt = 1'b1;
    repeat (2) row(1'b0, 1'b0, 1'b0);
    c_halt = 1'b0;
    repeat (4) row(1'b0, 1'b0, 1'b0);
    // Mode to step while high: applies at the fall
    row(1'b1, 1'b1, 1'b0);
    c_mode = 1'b1;
    repeat (3) row(1'b1, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b1);
    repeat (5) row(1'b0, 1'b0, 1'b0);
`ifndef CLOCK_CPU_DEBOUNCE_EN
    // Step pulse, with a second press inside the pulse
    c_step = 1'b1;
    repeat (2) row(1'b0, 1'b0, 1'b0);
    row(1'b1, 1'b1, 1'b0);
    c_step = 1'b0;
    row(1'b1, 1'b0, 1'b0);
    c_step = 1'b1;
    repeat (2) row(1'b1, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b1);
    repeat (4) row(1'b0, 1'b0, 1'b0);
    c_step = 1'b0;
    repeat (3) row(1'b0, 1'b0, 1'b0);
`endif
    // Mode back to run while low: immediate, full low phase first
    c_mode = 1'b0;
    repeat (4) row(1'b0, 1'b0, 1'b0);
    phase(4, 1'b1); phase(4, 1'b0);

    reset = 1'b1; mode = 1'b0; halt = 1'b0; step = 1'b0; load = 1'b0; half_period = 8'd0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", {5'd0, clk_cpu, clk_cpu_rise, clk_cpu_fall}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      load        = vecs[i].load;
      half_period = vecs[i].half;
      mode        = vecs[i].mode;
      halt        = vecs[i].halt;
      step        = vecs[i].step;
      @(posedge clk);
      #1 check($sformatf("row%0d", i), {5'd0, clk_cpu, clk_cpu_rise, clk_cpu_fall},
               {5'd0, vecs[i].exp});
      @(negedge clk);
    end
    load = 1'b0; mode = 1'b0; halt = 1'b0; step = 1'b0;

    // Reset in the middle of a high phase
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 if (clk_cpu) found = 1'b1;
    end
    check("seek_high", {7'd0, found}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; mode = 1'b1;
    @(posedge clk);
    #1 check("reset_mid", {5'd0, clk_cpu, clk_cpu_rise, clk_cpu_fall}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_high = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (clk_cpu || clk_cpu_rise || clk_cpu_fall) saw_high = 1'b1;
    end
    check("step_mode_reset_idle", {7'd0, saw_high}, 8'd0);

    @(negedge clk);
    reset = 1'b1; mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rise_at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1 if (clk_cpu_rise && rise_at == 0) rise_at = i;
    end
    check("first_rise_after_reset", 8'(rise_at), 8'd4);

`ifdef CLOCK_CPU_DEBOUNCE_EN
    @(negedge clk);
    reset = 1'b1; mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rises = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        step = (i < 5);
        @(posedge clk);
        #1 if (clk_cpu_rise) rises++;
      end
    end
    check("bounce_rejected", 8'(rises), 8'd0);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      step = (i < 12);
      @(posedge clk);
      #1 if (clk_cpu_rise) rises++;
    end
    check("hold_one_pulse", 8'(rises), 8'd1);
`else
    rises = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
